// File: rtl/vigna_bus_mem.sv
// Dual-port valid/ready memory responder for the vigna instruction and data buses.
// Each port runs an IDLE/WAIT/ACK FSM with a fixed latency plus optional LFSR stalls.
module vigna_bus_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned I_LATENCY   = 1,
  parameter int unsigned D_LATENCY   = 1,
  parameter bit          STALL_EN    = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  output logic        d_ready,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic [31:0] d_rdata
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  logic [31:0] mem [DEPTH_WORDS];

  initial begin
    for (int k = 0; k < DEPTH_WORDS; k++) mem[k] = 32'h0;
  end

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  logic [15:0]   lfsr_q, lfsr_d;
  state_e        i_state_q, i_state_d, d_state_q, d_state_d;
  logic [4:0]    i_cnt_q, i_cnt_d, d_cnt_q, d_cnt_d;
  logic [AW-1:0] i_idx_q, i_idx_d, d_idx_q, d_idx_d;
  logic          i_ready_q, i_ready_d, d_ready_q, d_ready_d;
  logic [31:0]   i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic [31:0]   d_wdata_q, d_wdata_d;
  logic [3:0]    d_wstrb_q, d_wstrb_d;
  logic [4:0]    i_load, d_load;
  logic          mem_we;

  assign i_load = 5'(I_LATENCY - 1) + (STALL_EN ? {3'b000, lfsr_q[1:0]} : 5'd0);
  assign d_load = 5'(D_LATENCY - 1) + (STALL_EN ? {3'b000, lfsr_q[3:2]} : 5'd0);

  always_comb begin
    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // A zero wait load skips WAIT entirely so ready lands exactly LATENCY+extra cycles after acceptance.
  always_comb begin
    i_state_d = i_state_q;
    i_cnt_d   = i_cnt_q;
    i_idx_d   = i_idx_q;
    i_ready_d = 1'b0;
    i_rdata_d = i_rdata_q;
    case (i_state_q)
      S_IDLE: begin
        if (i_valid) begin
          i_idx_d = i_addr[AW+1:2];
          i_cnt_d = i_load;
          if (i_load == 5'd0) begin
            i_state_d = S_ACK;
            i_ready_d = 1'b1;
            i_rdata_d = mem[i_addr[AW+1:2]];
          end else begin
            i_state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!i_valid) begin
          i_state_d = S_IDLE;
        end else begin
          i_cnt_d = i_cnt_q - 5'd1;
          if (i_cnt_q == 5'd1) begin
            i_state_d = S_ACK;
            i_ready_d = 1'b1;
            i_rdata_d = mem[i_idx_q];
          end
        end
      end
      default: i_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    d_state_d = d_state_q;
    d_cnt_d   = d_cnt_q;
    d_idx_d   = d_idx_q;
    d_wdata_d = d_wdata_q;
    d_wstrb_d = d_wstrb_q;
    d_ready_d = 1'b0;
    d_rdata_d = d_rdata_q;
    case (d_state_q)
      S_IDLE: begin
        if (d_valid) begin
          d_idx_d   = d_addr[AW+1:2];
          d_wdata_d = d_wdata;
          d_wstrb_d = d_wstrb;
          d_cnt_d   = d_load;
          if (d_load == 5'd0) begin
            d_state_d = S_ACK;
            d_ready_d = 1'b1;
            d_rdata_d = (d_wstrb != 4'b0) ? 32'h0 : mem[d_addr[AW+1:2]];
          end else begin
            d_state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!d_valid) begin
          d_state_d = S_IDLE;
        end else begin
          d_cnt_d = d_cnt_q - 5'd1;
          if (d_cnt_q == 5'd1) begin
            d_state_d = S_ACK;
            d_ready_d = 1'b1;
            d_rdata_d = (d_wstrb_q != 4'b0) ? 32'h0 : mem[d_idx_q];
          end
        end
      end
      default: d_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q    <= LFSR_SEED;
      i_state_q <= S_IDLE;
      i_ready_q <= 1'b0;
      i_rdata_q <= 32'h0;
      d_state_q <= S_IDLE;
      d_ready_q <= 1'b0;
      d_rdata_q <= 32'h0;
    end else begin
      lfsr_q    <= lfsr_d;
      i_state_q <= i_state_d;
      i_ready_q <= i_ready_d;
      i_rdata_q <= i_rdata_d;
      d_state_q <= d_state_d;
      d_ready_q <= d_ready_d;
      d_rdata_q <= d_rdata_d;
    end
    i_cnt_q   <= i_cnt_d;
    i_idx_q   <= i_idx_d;
    d_cnt_q   <= d_cnt_d;
    d_idx_q   <= d_idx_d;
    d_wdata_q <= d_wdata_d;
    d_wstrb_q <= d_wstrb_d;
  end

  // The write lands on the edge leaving ACK, after any same-edge read capture has sampled old data.
  assign mem_we = (d_state_q == S_ACK) && (d_wstrb_q != 4'b0) && !reset;

  always @(posedge clk) begin
    if (mem_we) mem[d_idx_q] <= merge_bytes(mem[d_idx_q], d_wdata_q, d_wstrb_q);
  end

  assign i_ready = i_ready_q;
  assign i_rdata = i_rdata_q;
  assign d_ready = d_ready_q;
  assign d_rdata = d_rdata_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:AW+2], i_addr[1:0], d_addr[31:AW+2], d_addr[1:0]};

endmodule

// File: tb/tb_vigna_bus_mem.sv
// Bench for vigna_bus_mem: a fixed-latency instance (A) and a stalling instance (B)
// driven by scenario tasks and compared against a word-array reference model.
module tb_vigna_bus_mem;

    localparam int A_DEPTH = 64;
    localparam int A_IL    = 1;
    localparam int A_DL    = 3;
    localparam int B_DEPTH = 16;
    localparam int B_IL    = 2;
    localparam int B_DL    = 5;
    localparam int TMO     = 40;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        a_i_valid = 0, a_i_ready, a_d_valid = 0, a_d_ready;
    logic [31:0] a_i_addr = 0, a_i_rdata, a_d_addr = 0, a_d_wdata = 0, a_d_rdata;
    logic [3:0]  a_d_wstrb = 0;
    logic        b_i_valid = 0, b_i_ready, b_d_valid = 0, b_d_ready;
    logic [31:0] b_i_addr = 0, b_i_rdata, b_d_addr = 0, b_d_wdata = 0, b_d_rdata;
    logic [3:0]  b_d_wstrb = 0;

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_a [A_DEPTH];
    logic [31:0] ref_b [B_DEPTH];

    vigna_bus_mem #(.DEPTH_WORDS(A_DEPTH), .I_LATENCY(A_IL), .D_LATENCY(A_DL), .STALL_EN(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .i_valid(a_i_valid), .i_ready(a_i_ready), .i_addr(a_i_addr), .i_rdata(a_i_rdata),
        .d_valid(a_d_valid), .d_ready(a_d_ready), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_wstrb(a_d_wstrb), .d_rdata(a_d_rdata)
    );

    vigna_bus_mem #(.DEPTH_WORDS(B_DEPTH), .I_LATENCY(B_IL), .D_LATENCY(B_DL), .STALL_EN(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .i_valid(b_i_valid), .i_ready(b_i_ready), .i_addr(b_i_addr), .i_rdata(b_i_rdata),
        .d_valid(b_d_valid), .d_ready(b_d_ready), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_wstrb(b_d_wstrb), .d_rdata(b_d_rdata)
    );

    function automatic int word_of(input bit sel, input logic [31:0] addr);
        return int'((addr >> 2) % (sel ? B_DEPTH : A_DEPTH));
    endfunction

    function automatic logic [31:0] model_read(input bit sel, input logic [31:0] addr);
        return sel ? ref_b[word_of(1'b1, addr)] : ref_a[word_of(1'b0, addr)];
    endfunction

    task automatic model_write(input bit sel, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb);
        logic [31:0] w;
        w = model_read(sel, addr);
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = wdata[8*b +: 8];
        if (sel) ref_b[word_of(1'b1, addr)] = w;
        else     ref_a[word_of(1'b0, addr)] = w;
    endtask

    // One instruction read; lat = cycles from acceptance to ready (-1 on timeout).
    task automatic i_xfer(input bit sel, input logic [31:0] addr,
                          output logic [31:0] data, output int lat, output bit pulse_ok);
        lat = -1;
        data = 32'hx;
        if (sel) begin b_i_valid = 1; b_i_addr = addr; end
        else     begin a_i_valid = 1; a_i_addr = addr; end
        for (int n = 1; n <= TMO; n++) begin
            @(posedge clk); #1;
            if ((sel ? b_i_ready : a_i_ready) === 1'b1) begin
                lat = n;
                data = sel ? b_i_rdata : a_i_rdata;
                break;
            end
        end
        if (sel) b_i_valid = 0; else a_i_valid = 0;
        @(posedge clk); #1;
        pulse_ok = ((sel ? b_i_ready : a_i_ready) === 1'b0);
    endtask

    task automatic d_xfer(input bit sel, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] data, output int lat,
                          output bit pulse_ok);
        lat = -1;
        data = 32'hx;
        if (sel) begin b_d_valid = 1; b_d_addr = addr; b_d_wdata = wdata; b_d_wstrb = strb; end
        else     begin a_d_valid = 1; a_d_addr = addr; a_d_wdata = wdata; a_d_wstrb = strb; end
        for (int n = 1; n <= TMO; n++) begin
            @(posedge clk); #1;
            if ((sel ? b_d_ready : a_d_ready) === 1'b1) begin
                lat = n;
                data = sel ? b_d_rdata : a_d_rdata;
                break;
            end
        end
        if (sel) b_d_valid = 0; else a_d_valid = 0;
        @(posedge clk); #1;
        pulse_ok = ((sel ? b_d_ready : a_d_ready) === 1'b0);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_i_ready, a_d_ready, b_i_ready, b_d_ready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0000", {a_i_ready, a_d_ready, b_i_ready, b_d_ready});
        end
        checks++;
        if ({a_i_rdata, a_d_rdata, b_i_rdata, b_d_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h want 0", {a_i_rdata, a_d_rdata, b_i_rdata, b_d_rdata});
        end
        reset = 0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++;
            if ({a_i_ready, a_d_ready, b_i_ready, b_d_ready} !== 4'b0) begin
                errors++;
                $display("FAIL idle_ready: got %b want 0000", {a_i_ready, a_d_ready, b_i_ready, b_d_ready});
            end
        end
    endtask

    task automatic test_ifetch_latency();
        logic [31:0] rd;
        int lat;
        bit p;
        d_xfer(0, 32'h0, 32'h00000013, 4'hF, rd, lat, p);
        model_write(0, 32'h0, 32'h00000013, 4'hF);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL write_rdata_zero: got %h want 0", rd); end
        i_xfer(0, 32'h0, rd, lat, p);
        checks++;
        if (lat !== A_IL) begin errors++; $display("FAIL i_latency: got %0d want %0d", lat, A_IL); end
        checks++;
        if (rd !== 32'h00000013) begin errors++; $display("FAIL i_rdata_word0: got %h want 00000013", rd); end
        checks++;
        if (!p) begin errors++; $display("FAIL i_ready_pulse: got ready held want 1-cycle pulse"); end
    endtask

    task automatic test_byte_strobes();
        logic [31:0] rd;
        int lat;
        bit p;
        d_xfer(0, 32'h10, 32'h11223344, 4'hF, rd, lat, p);
        model_write(0, 32'h10, 32'h11223344, 4'hF);
        d_xfer(0, 32'h10, 32'hAABBCCDD, 4'b0101, rd, lat, p);
        model_write(0, 32'h10, 32'hAABBCCDD, 4'b0101);
        checks++;
        if (rd !== 32'h0) begin errors++; $display("FAIL strb_write_rdata: got %h want 0", rd); end
        checks++;
        if (lat !== A_DL) begin errors++; $display("FAIL d_latency: got %0d want %0d", lat, A_DL); end
        checks++;
        if (!p) begin errors++; $display("FAIL d_ready_pulse: got ready held want 1-cycle pulse"); end
        d_xfer(0, 32'h10, 32'h0, 4'h0, rd, lat, p);
        checks++;
        if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL strb_readback: got %h want 11BB33DD", rd); end
        // upper and low address bits must be ignored
        i_xfer(0, 32'h8000_0013 + A_DEPTH * 4, rd, lat, p);
        checks++;
        if (rd !== model_read(0, 32'h10)) begin
            errors++;
            $display("FAIL addr_wrap: got %h want %h", rd, model_read(0, 32'h10));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, d1, d2;
        int lat, first, second;
        bit p;
        d_xfer(0, 32'h4, 32'h1111_0001, 4'hF, rd, lat, p);
        model_write(0, 32'h4, 32'h1111_0001, 4'hF);
        d_xfer(0, 32'h8, 32'h2222_0002, 4'hF, rd, lat, p);
        model_write(0, 32'h8, 32'h2222_0002, 4'hF);
        first = -1;
        second = -1;
        d1 = 32'hx;
        d2 = 32'hx;
        a_d_valid = 1; a_d_addr = 32'h4; a_d_wstrb = 4'h0;
        for (int n = 1; n <= TMO; n++) begin
            @(posedge clk); #1;
            if (a_d_ready === 1'b1) begin
                if (first < 0) begin
                    first = n; d1 = a_d_rdata; a_d_addr = 32'h8;
                end else begin
                    second = n; d2 = a_d_rdata; break;
                end
            end
        end
        a_d_valid = 0;
        @(posedge clk); #1;
        checks++;
        if (first !== A_DL) begin errors++; $display("FAIL b2b_first_lat: got %0d want %0d", first, A_DL); end
        checks++;
        if (second - first !== A_DL + 1) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d want %0d", second - first, A_DL + 1);
        end
        checks++;
        if (d1 !== 32'h1111_0001) begin errors++; $display("FAIL b2b_data1: got %h want 11110001", d1); end
        checks++;
        if (d2 !== 32'h2222_0002) begin errors++; $display("FAIL b2b_data2: got %h want 22220002", d2); end
    endtask

    task automatic test_collision();
        logic [31:0] rd;
        int lat;
        bit p;
        d_xfer(0, 32'h20, 32'h0BAD_F00D, 4'hF, rd, lat, p);
        model_write(0, 32'h20, 32'h0BAD_F00D, 4'hF);
        a_d_valid = 1; a_d_addr = 32'h20; a_d_wdata = 32'hDEADBEEF; a_d_wstrb = 4'hF;
        repeat (A_DL) @(posedge clk);
        #1;
        checks++;
        if (a_d_ready !== 1'b1) begin errors++; $display("FAIL coll_d_ack: got %b want 1", a_d_ready); end
        a_d_valid = 0;
        a_i_valid = 1; a_i_addr = 32'h20;
        @(posedge clk); #1;
        checks++;
        if (a_i_ready !== 1'b1) begin errors++; $display("FAIL coll_i_ack: got %b want 1", a_i_ready); end
        checks++;
        if (a_i_rdata !== 32'h0BAD_F00D) begin
            errors++;
            $display("FAIL coll_old_data: got %h want 0BADF00D", a_i_rdata);
        end
        a_i_valid = 0;
        model_write(0, 32'h20, 32'hDEADBEEF, 4'hF);
        @(posedge clk); #1;
        i_xfer(0, 32'h20, rd, lat, p);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL coll_new_data: got %h want DEADBEEF", rd); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        int lat, seen;
        bit p;
        d_xfer(1, 32'hC, 32'h3333_3333, 4'hF, rd, lat, p);
        model_write(1, 32'hC, 32'h3333_3333, 4'hF);
        i_xfer(1, 32'hC, rd, lat, p);
        d_xfer(1, 32'hC, 32'h0, 4'h0, rd, lat, p);
        checks++;
        if (rd !== 32'h3333_3333) begin errors++; $display("FAIL rst_pre_read: got %h want 33333333", rd); end
        b_d_valid = 1; b_d_addr = 32'hC; b_d_wdata = 32'hCAFEBABE; b_d_wstrb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        b_d_valid = 0;
        @(posedge clk); #1;
        reset = 0;
        checks++;
        if ({b_i_ready, b_d_ready, b_i_rdata, b_d_rdata} !== 66'h0) begin
            errors++;
            $display("FAIL rst_outputs: got %h want 0", {b_i_ready, b_d_ready, b_i_rdata, b_d_rdata});
        end
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (b_d_ready === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL rst_no_ready: got %0d pulses want 0", seen); end
        d_xfer(1, 32'hC, 32'h0, 4'h0, rd, lat, p);
        checks++;
        if (lat < B_DL || lat > B_DL + 3) begin
            errors++;
            $display("FAIL rst_next_lat: got %0d want %0d..%0d", lat, B_DL, B_DL + 3);
        end
        checks++;
        if (rd !== 32'h3333_3333) begin errors++; $display("FAIL rst_word_kept: got %h want 33333333", rd); end
    endtask

    task automatic test_random_stall();
        int i_bins[4];
        int d_bins[4];
        logic [31:0] ia, da, wd, ri, rdd, exp_i, exp_d;
        logic [3:0] ws;
        int li, ld;
        bit pi, pd, dwr;
        for (int k = 0; k < 4; k++) begin i_bins[k] = 0; d_bins[k] = 0; end
        for (int it = 0; it < 1000; it++) begin
            ia = $urandom;
            da = $urandom;
            dwr = ($urandom_range(0, 3) == 0);
            while (dwr && word_of(1'b1, da) == word_of(1'b1, ia)) da = $urandom;
            wd = $urandom;
            ws = dwr ? 4'($urandom_range(1, 15)) : 4'h0;
            exp_i = model_read(1, ia);
            exp_d = dwr ? 32'h0 : model_read(1, da);
            fork
                i_xfer(1, ia, ri, li, pi);
                d_xfer(1, da, wd, ws, rdd, ld, pd);
            join
            if (dwr) model_write(1, da, wd, ws);
            checks++;
            if (li < B_IL || li > B_IL + 3) begin
                errors++;
                $display("FAIL rand_i_lat it=%0d: got %0d want %0d..%0d", it, li, B_IL, B_IL + 3);
            end else i_bins[li - B_IL]++;
            checks++;
            if (ri !== exp_i) begin errors++; $display("FAIL rand_i_data it=%0d: got %h want %h", it, ri, exp_i); end
            checks++;
            if (ld < B_DL || ld > B_DL + 3) begin
                errors++;
                $display("FAIL rand_d_lat it=%0d: got %0d want %0d..%0d", it, ld, B_DL, B_DL + 3);
            end else d_bins[ld - B_DL]++;
            checks++;
            if (rdd !== exp_d) begin errors++; $display("FAIL rand_d_data it=%0d: got %h want %h", it, rdd, exp_d); end
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (i_bins[k] == 0) begin errors++; $display("FAIL i_extra_%0d: got 0 occurrences want >0", k); end
            checks++;
            if (d_bins[k] == 0) begin errors++; $display("FAIL d_extra_%0d: got 0 occurrences want >0", k); end
        end
    endtask

    initial begin
        for (int k = 0; k < A_DEPTH; k++) ref_a[k] = 32'h0;
        for (int k = 0; k < B_DEPTH; k++) ref_b[k] = 32'h0;
        test_reset();
        test_ifetch_latency();
        test_byte_strobes();
        test_back_to_back();
        test_collision();
        test_reset_in_wait();
        test_random_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
